// File: rtl/irq_pending_ctrl_pkg.sv
// irq_pkg: register map, grant state encoding and priority encoder shared with the sequencer
package irq_pkg;
  localparam logic [1:0] REG_CONF = 2'd0;
  localparam logic [1:0] REG_TRIG = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_ISR  = 2'd3;
  typedef enum logic {ARM = 1'b0, SERVICE = 1'b1} gstate_t;
  function automatic logic [3:0] prio_enc8(input logic [7:0] v);
    prio_enc8 = 4'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) prio_enc8 = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/irq_pending_ctrl_if.sv
// irq_pending_ctrl_if: peripheral lines, sequencer handshake and register port
interface irq_pending_ctrl_if;
  logic [7:0]  irq_src;
  logic        seq_busy;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic [7:0]  interrupts;
  logic [15:0] conf;
  logic [7:0]  isr;
  modport master(output irq_src, seq_busy, reg_we, reg_addr, reg_wdata, input reg_rdata, interrupts, conf, isr);
  modport slave(input irq_src, seq_busy, reg_we, reg_addr, reg_wdata, output reg_rdata, interrupts, conf, isr);
endinterface

// File: rtl/irq_pending_ctrl_sync.sv
// irq_sync_edge: multi-flop synchroniser for one IRQ line plus rising-edge detect
module irq_sync_edge #(parameter int SYNC_ST = 2) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic irq_s,
  output logic rise
);
  logic [SYNC_ST-1:0] sr;
  logic irq_d;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sr    <= '0;
      irq_d <= 1'b0;
    end else begin
      sr    <= {sr[SYNC_ST-2:0], d};
      irq_d <= irq_s;
    end
  end
  assign irq_s = sr[SYNC_ST-1];
  assign rise  = irq_s & ~irq_d;
endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: latches synchronised IRQs as pending bits, tracks in-service nesting, one grant per sequencer run
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int NIRQ    = 8,
  parameter int SYNC_ST = 2
) (
  input logic CLK,
  input logic RST,
  irq_pending_ctrl_if.slave bus
);
  logic [15:0] conf_r;
  logic [7:0]  trig, pend, isr_r, irq_s, rise, blocked, ints, set, w1c, eoi_m, gnt_m;
  logic [3:0]  hp, gp;
  logic        busy_d, wr;
  gstate_t     gs, gs_n;
  for (genvar i = 0; i < NIRQ; i++) begin : g_sync
    irq_sync_edge #(.SYNC_ST(SYNC_ST)) u_sync (.CLK(CLK), .RST(RST), .d(bus.irq_src[i]), .irq_s(irq_s[i]), .rise(rise[i]));
  end
  always_comb begin
    hp      = prio_enc8(isr_r);
    blocked = hp[3] ? (8'hFF << hp[2:0]) : 8'h00;
    ints    = pend & conf_r[7:0] & ~blocked;
    gp      = prio_enc8(ints);
    wr      = bus.reg_we;
    w1c     = (wr && bus.reg_addr == REG_PEND) ? bus.reg_wdata[7:0] : 8'h00;
    eoi_m   = (wr && bus.reg_addr == REG_ISR && hp[3]) ? (8'd1 << hp[2:0]) : 8'h00;
    set     = (trig & rise) | (~trig & irq_s & ~isr_r);
    gs_n    = gs;
    gnt_m   = 8'h00;
    if (gs == ARM) begin
      if (bus.seq_busy && !busy_d) begin
        gs_n  = SERVICE;
        gnt_m = gp[3] ? (8'd1 << gp[2:0]) : 8'h00;
      end
    end else if (!bus.seq_busy) begin
      gs_n = ARM;
    end
  end
  // busy_d keeps tracking through reset so a run already in progress is never taken as a new one
  always_ff @(posedge CLK) busy_d <= bus.seq_busy;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      conf_r <= '0;
      trig   <= '0;
      pend   <= '0;
      isr_r  <= '0;
      gs     <= ARM;
    end else begin
      if (wr && bus.reg_addr == REG_CONF) conf_r <= bus.reg_wdata;
      if (wr && bus.reg_addr == REG_TRIG) trig <= bus.reg_wdata[7:0];
      pend  <= ((pend & ~w1c) | set) & ~gnt_m;
      isr_r <= (isr_r & ~eoi_m) | gnt_m;
      gs    <= gs_n;
    end
  end
  assign bus.interrupts = ints;
  assign bus.conf       = conf_r;
  assign bus.isr        = isr_r;
  assign bus.reg_rdata  = bus.reg_addr == REG_CONF ? conf_r :
                          bus.reg_addr == REG_TRIG ? {8'h00, trig} :
                          bus.reg_addr == REG_PEND ? {8'h00, pend} : {8'h00, isr_r};
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: randomized stimulus against a per-channel behavioural model, scoreboard-checked each cycle
module tb_irq_pending_ctrl;
  import irq_pkg::*;
  localparam int SS = 2;
  typedef struct {
    logic [7:0]  ints;
    logic [7:0]  isr;
    logic [15:0] conf;
    logic [15:0] rdata;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [15:0] m_conf;
  logic [7:0]  m_trig, m_pend, m_isr;
  bit          m_svc, m_pb, m_ok;
  logic [7:0]  hist[$];
  always #5 CLK = ~CLK;
  irq_pending_ctrl_if bus();
  irq_pending_ctrl #(.NIRQ(8), .SYNC_ST(SS)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction
  function automatic logic [7:0] m_ints();
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = m_pend[i] & m_conf[i] & (i < lowest(m_isr));
    return r;
  endfunction
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic step(input bit rst, input logic [7:0] src, input bit busy, input bit we,
                      input logic [1:0] addr, input logic [15:0] wd);
    exp_t e;
    logic [7:0] s, d, ints, np;
    int hp, g;
    RST = rst;
    bus.irq_src = src;
    bus.seq_busy = busy;
    bus.reg_we = we;
    bus.reg_addr = addr;
    bus.reg_wdata = wd;
    if (m_ok) begin
      e.ints  = m_ints();
      e.isr   = m_isr;
      e.conf  = m_conf;
      e.rdata = addr == 0 ? m_conf : addr == 1 ? {8'h00, m_trig} : addr == 2 ? {8'h00, m_pend} : {8'h00, m_isr};
      q.push_back(e);
    end
    @(posedge CLK);
    if (!rst) begin
      m_conf = 0; m_trig = 0; m_pend = 0; m_isr = 0; m_svc = 0; m_ok = 1;
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back(8'h00);
    end else begin
      s = hist[hist.size()-SS];
      d = hist[hist.size()-SS-1];
      ints = m_ints();
      hp = lowest(m_isr);
      g = 8;
      if (!m_svc && busy && !m_pb) begin
        m_svc = 1;
        g = lowest(ints);
      end else if (m_svc && !busy) m_svc = 0;
      for (int i = 0; i < 8; i++) begin
        np[i] = (m_pend[i] && !(we && addr == 2 && wd[i])) ||
                (m_trig[i] ? (s[i] && !d[i]) : (s[i] && !m_isr[i]));
        if (i == g) np[i] = 1'b0;
      end
      m_pend = np;
      if (we && addr == 3 && hp < 8) m_isr[hp] = 1'b0;
      if (g < 8) m_isr[g] = 1'b1;
      if (we && addr == 0) m_conf = wd;
      if (we && addr == 1) m_trig = wd[7:0];
      hist.push_back(src);
      void'(hist.pop_front());
    end
    m_pb = busy;
    #1;
  endtask
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("interrupts", {8'h00, bus.interrupts}, {8'h00, e.ints});
      chk("isr", {8'h00, bus.isr}, {8'h00, e.isr});
      chk("conf", bus.conf, e.conf);
      chk("reg_rdata", bus.reg_rdata, e.rdata);
    end
  end
  initial begin
    logic [7:0] src;
    bit busy, we, rst;
    int cnt;
    logic [1:0] addr;
    logic [15:0] wd;
    m_ok = 0; m_pb = 0;
    src = 8'hFF; busy = 0; cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 8'hFF, 1'b0, 1'b0, 2'(i), 16'h0);
    step(1'b1, 8'h00, 1'b0, 1'b1, REG_CONF, 16'h00FF);
    step(1'b1, 8'h00, 1'b0, 1'b1, REG_TRIG, 16'h000F);
    src = 8'h00;
    for (int n = 0; n < 6000; n++) begin
      rst = $urandom_range(0, 299) != 0;
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 9) == 0) src[i] = ~src[i];
      if (busy) begin
        if (cnt == 0) busy = 0; else cnt--;
      end else if ($urandom_range(0, 5) == 0) begin
        busy = 1;
        cnt = $urandom_range(0, 5);
      end
      we = $urandom_range(0, 4) == 0;
      addr = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      step(rst, src, busy, we, addr, wd);
    end
    step(1'b1, src, 1'b0, 1'b0, REG_PEND, 16'h0);
    @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
